vertical_strip_extractor: RTL and testbench
===========================================

Name: vertical_strip_extractor

Overview:
- Captures one binary image frame, delivered as a raster-order pixel stream, into an internal frame buffer.
- Replays the buffered frame column by column as HEIGHT-bit vertical strips.
- Acts as the producer side of the vertical-strip interface: each emitted strip feeds the vertical transition counter in the feature-extraction path ahead of the neural-net input layer.

Parameters:
- WIDTH, 28, image columns per frame; one strip is emitted per column.
- HEIGHT, 28, image rows per frame; this is the strip width in bits.
- COL_W, $clog2(WIDTH), width of the column index.
- ROW_W, $clog2(HEIGHT), width of the row index.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_valid  input  1  pixel present on pix_data.
- pix_ready  output  1  block can accept a pixel this cycle.
- pix_data  input  1  binary pixel value (1 = ink).
- pix_sof  input  1  start of frame; qualifies the pixel as row 0, column 0.
- strip_valid  output  1  strip_data holds a valid column.
- strip_ready  input  1  downstream accepts the strip this cycle.
- strip_data  output  HEIGHT  column pixels; bit r = row r, row 0 = top.
- strip_col  output  COL_W  column index of the current strip.
- strip_last  output  1  current strip is column WIDTH-1.
- frame_done  output  1  one-cycle pulse when the last strip is accepted.

Behaviour:
- Reset (asynchronous, rst=1): FSM to FILL; row/col write counters and column read counter to 0; frame buffer to all 0.
- Output values during reset: pix_ready=1, strip_valid=0, strip_data=0, strip_col=0, strip_last=0, frame_done=0.
- Reset asserted mid-frame or mid-drain discards all partial data; no strip is emitted for that frame.
- FSM has two states, FILL and DRAIN.
- FILL:
  - pix_ready=1 and strip_valid=0.
  - A pixel is accepted when pix_valid && pix_ready. It is written to buffer[row][col].
  - After a write, col increments; at col=WIDTH-1, col wraps to 0 and row increments.
  - pix_sof=1 on an accepted pixel forces the write to (0,0). Counters then continue from (0,1), so an earlier partial frame is overwritten.
  - pix_sof on a non-accepted cycle is ignored.
  - The pixel written at (HEIGHT-1, WIDTH-1) moves the FSM to DRAIN on the next edge and resets the write counters to 0.
- DRAIN:
  - pix_ready=0; input pixels are back-pressured and not dropped.
  - strip_valid=1; strip_data is a combinational mux of buffer[*][rd_col].
  - strip_col=rd_col; strip_last=(rd_col==WIDTH-1).
  - strip_data, strip_col and strip_last stay stable while strip_valid && !strip_ready.
  - strip_valid does not drop while waiting for strip_ready.
  - On strip_valid && strip_ready, rd_col increments.
  - On acceptance with strip_last=1: rd_col returns to 0, frame_done pulses high for the following cycle, and the FSM returns to FILL.
- Latency:
  - Last pixel accepted at cycle N gives strip_valid=1 with column 0 at cycle N+1.
  - With strip_ready held at 1, one strip is accepted per cycle, so a frame drains in WIDTH cycles.
  - pix_ready returns to 1 the cycle after the last strip is accepted.
- The buffer is not cleared between frames. Every location is rewritten before the next DRAIN, so this is not observable.
- Counter widths wrap only at the WIDTH-1 and HEIGHT-1 bounds, never at a power of two.

Decomposition:
- Shared package strip_pkg:
  - WIDTH and HEIGHT, moved from the global params header.
  - COL_W and ROW_W.
  - typedef strip_t = logic [HEIGHT-1:0].
  - typedef enum {FILL, DRAIN} strip_state_t.
- The transition counter and this block both import strip_pkg.
- The block stays flat; a separate buffer sub-module adds nothing.

Test Plan (all scenarios WIDTH=4, HEIGHT=4 unless stated):
- Reset check: hold rst=1, then release -> pix_ready=1, strip_valid=0, strip_data=0, frame_done=0. Assert rst asynchronously mid-cycle -> outputs clear before the next clk edge.
- Identity frame: stream rows 1000/0100/0010/0001 (col 0 first) with strip_ready=1 -> next cycle strip_data = 4'b0001, 4'b0010, 4'b0100, 4'b1000 for cols 0..3. strip_last only on col 3; frame_done one cycle after.
- Back-pressure: all-ones frame, strip_ready=0 for 5 cycles then 1 -> strip_col=0 and strip_data=4'hF held stable, pix_ready=0 throughout DRAIN, no strip skipped.
- Resync: feed 6 pixels, then pix_sof=1 with a new full checkerboard frame (rows 1010/0101/1010/0101) -> strips 4'b0101, 4'b1010, 4'b0101, 4'b1010. Earlier pixels leave no trace.
- Reset mid-drain: assert rst after strip 1 is accepted -> strip_valid=0 immediately. The next full frame drains from col 0.
- Default size: WIDTH=HEIGHT=28 with a random frame checked against a reference model -> 28 strips, strip_col 0..27, and each strip's transition count matches the model.

Source files
------------

// File: rtl/strip_pkg.sv
// Shared definitions for the vertical-strip interface between the frame
// buffer (producer) and the vertical transition counter (consumer).
package strip_pkg;

   localparam int WIDTH  = 28;
   localparam int HEIGHT = 28;
   localparam int COL_W  = $clog2(WIDTH);
   localparam int ROW_W  = $clog2(HEIGHT);

   typedef logic [HEIGHT-1:0] strip_t;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } strip_state_t;

endpackage

// File: rtl/vertical_strip_extractor.sv
// Buffers one raster-order binary frame, then replays it column by column
// as HEIGHT-bit vertical strips with a valid/ready handshake.
module vertical_strip_extractor #(
   parameter int WIDTH  = strip_pkg::WIDTH,
   parameter int HEIGHT = strip_pkg::HEIGHT,
   parameter int COL_W  = $clog2(WIDTH),
   parameter int ROW_W  = $clog2(HEIGHT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic              pix_data,
   input  logic              pix_sof,
   output logic              strip_valid,
   input  logic              strip_ready,
   output logic [HEIGHT-1:0] strip_data,
   output logic [COL_W-1:0]  strip_col,
   output logic              strip_last,
   output logic              frame_done
);

   import strip_pkg::strip_state_t;
   import strip_pkg::FILL;
   import strip_pkg::DRAIN;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

   strip_state_t      r_state;
   logic [ROW_W-1:0]  r_wrRow;
   logic [COL_W-1:0]  r_wrCol;
   logic [COL_W-1:0]  r_rdCol;
   logic              r_frameDone;
   logic [HEIGHT-1:0] r_buffer [WIDTH];

   logic              w_pixAccept;
   logic              w_stripAccept;
   logic [ROW_W-1:0]  w_row;
   logic [COL_W-1:0]  w_col;
   logic              w_frameEnd;

   // Start-of-frame overrides the write position, so a partial frame is
   // simply overwritten by the new one.
   assign w_pixAccept   = pix_valid && (r_state == FILL);
   assign w_row         = pix_sof ? '0 : r_wrRow;
   assign w_col         = pix_sof ? '0 : r_wrCol;
   assign w_frameEnd    = (w_row == LAST_ROW) && (w_col == LAST_COL);
   assign w_stripAccept = (r_state == DRAIN) && strip_ready;

   // Frame buffer is stored column-major so a strip is a single word read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < WIDTH; c++) begin
            r_buffer[c] <= '0;
         end
      end else if (w_pixAccept) begin
         r_buffer[w_col][w_row] <= pix_data;
      end
   end

   // Raster write position; wraps back to (0,0) after the last pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrRow <= '0;
         r_wrCol <= '0;
      end else if (w_pixAccept) begin
         if (w_col == LAST_COL) begin
            r_wrCol <= '0;
            r_wrRow <= (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
         end else begin
            r_wrCol <= w_col + 1'b1;
            r_wrRow <= w_row;
         end
      end
   end

   // FILL/DRAIN sequencing, read column and the end-of-frame pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= FILL;
         r_rdCol     <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         case (r_state)
            FILL: begin
               if (w_pixAccept && w_frameEnd) begin
                  r_state <= DRAIN;
                  r_rdCol <= '0;
               end
            end
            DRAIN: begin
               if (w_stripAccept) begin
                  if (r_rdCol == LAST_COL) begin
                     r_rdCol     <= '0;
                     r_frameDone <= 1'b1;
                     r_state     <= FILL;
                  end else begin
                     r_rdCol <= r_rdCol + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

   assign pix_ready   = (r_state == FILL);
   assign strip_valid = (r_state == DRAIN);
   assign strip_data  = (r_state == DRAIN) ? r_buffer[r_rdCol] : '0;
   assign strip_col   = r_rdCol;
   assign strip_last  = (r_state == DRAIN) && (r_rdCol == LAST_COL);
   assign frame_done  = r_frameDone;

endmodule

// File: tb/tb_vertical_strip_extractor.sv
// Self-checking bench: a 4x4 instance for directed scenarios and a default
// 28x28 instance driven with a random frame against an image-array model.
module tb_vertical_strip_extractor;

   localparam int SW = 4;
   localparam int SH = 4;
   localparam int BW = 28;
   localparam int BH = 28;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          sPixValid = 1'b0, sPixReady, sPixData = 1'b0, sPixSof = 1'b0;
   logic          sStripValid, sStripReady = 1'b0, sStripLast, sFrameDone;
   logic [SH-1:0] sStripData;
   logic [1:0]    sStripCol;

   logic          bPixValid = 1'b0, bPixReady, bPixData = 1'b0, bPixSof = 1'b0;
   logic          bStripValid, bStripReady = 1'b0, bStripLast, bFrameDone;
   logic [BH-1:0] bStripData;
   logic [4:0]    bStripCol;

   int total = 0;
   int bad   = 0;

   bit sImg [SH][SW];
   bit bImg [BH][BW];

   vertical_strip_extractor #(.WIDTH(SW), .HEIGHT(SH)) uSmall (
      .clk(clk), .rst(rst),
      .pix_valid(sPixValid), .pix_ready(sPixReady), .pix_data(sPixData), .pix_sof(sPixSof),
      .strip_valid(sStripValid), .strip_ready(sStripReady), .strip_data(sStripData),
      .strip_col(sStripCol), .strip_last(sStripLast), .frame_done(sFrameDone)
   );

   vertical_strip_extractor uBig (
      .clk(clk), .rst(rst),
      .pix_valid(bPixValid), .pix_ready(bPixReady), .pix_data(bPixData), .pix_sof(bPixSof),
      .strip_valid(bStripValid), .strip_ready(bStripReady), .strip_data(bStripData),
      .strip_col(bStripCol), .strip_last(bStripLast), .frame_done(bFrameDone)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Column c of the model image, row r in bit r.
   function automatic logic [SH-1:0] smallStrip(input int c);
      logic [SH-1:0] s;
      for (int r = 0; r < SH; r++) s[r] = sImg[r][c];
      return s;
   endfunction

   function automatic logic [BH-1:0] bigStrip(input int c);
      logic [BH-1:0] s;
      for (int r = 0; r < BH; r++) s[r] = bImg[r][c];
      return s;
   endfunction

   function automatic int modelTransitions(input int c);
      int n = 0;
      for (int r = 1; r < BH; r++) if (bImg[r][c] != bImg[r-1][c]) n++;
      return n;
   endfunction

   function automatic int stripTransitions(input logic [BH-1:0] s);
      int n = 0;
      for (int i = 1; i < BH; i++) if (s[i] !== s[i-1]) n++;
      return n;
   endfunction

   task automatic applyStimulus(input bit withSof);
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            total++;
            if (sPixReady !== 1'b1) begin
               bad++;
               $display("[TB] FAIL pix_ready fill r%0d c%0d: got %b expected 1", r, c, sPixReady);
            end
            sPixValid = 1'b1;
            sPixData  = sImg[r][c];
            sPixSof   = withSof && (r == 0) && (c == 0);
            tick();
         end
      end
      sPixValid = 1'b0;
      sPixSof   = 1'b0;
   endtask

   task automatic checkOutput(input int stallCycles, input bit holdPix);
      logic [SH-1:0] exp;
      if (holdPix) begin
         sPixValid = 1'b1;
         sPixData  = 1'b0;
      end
      for (int c = 0; c < SW; c++) begin
         exp = smallStrip(c);
         sStripReady = 1'b0;
         for (int k = 0; (c == 0) && (k < stallCycles); k++) begin
            total++;
            if (sStripValid !== 1'b1 || sStripCol !== 2'd0 || sStripData !== exp) begin
               bad++;
               $display("[TB] FAIL stall k%0d: got v=%b col=%0d data=%h expected v=1 col=0 data=%h",
                        k, sStripValid, sStripCol, sStripData, exp);
            end
            tick();
         end
         total++;
         if (sStripValid !== 1'b1 || sStripCol !== 2'(c)) begin
            bad++;
            $display("[TB] FAIL strip col%0d: got v=%b col=%0d expected v=1 col=%0d", c, sStripValid, sStripCol, c);
         end
         total++;
         if (sStripData !== exp) begin
            bad++;
            $display("[TB] FAIL strip_data col%0d: got %h expected %h", c, sStripData, exp);
         end
         total++;
         if (sStripLast !== (c == SW - 1) || sPixReady !== 1'b0) begin
            bad++;
            $display("[TB] FAIL last/ready col%0d: got last=%b ready=%b expected last=%b ready=0",
                     c, sStripLast, sPixReady, (c == SW - 1));
         end
         sStripReady = 1'b1;
         tick();
         sStripReady = 1'b0;
      end
      sPixValid = 1'b0;
      total++;
      if (sFrameDone !== 1'b1 || sPixReady !== 1'b1 || sStripValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL frame end: got done=%b ready=%b valid=%b expected 1 1 0",
                  sFrameDone, sPixReady, sStripValid);
      end
      tick();
      total++;
      if (sFrameDone !== 1'b0) begin
         bad++;
         $display("[TB] FAIL frame_done pulse width: got %b expected 0", sFrameDone);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      total++;
      if (sPixReady !== 1'b1 || sStripValid !== 1'b0 || sStripData !== 4'h0 ||
          sStripCol !== 2'd0 || sStripLast !== 1'b0 || sFrameDone !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset hold: got rdy=%b v=%b d=%h col=%0d last=%b done=%b expected 1 0 0 0 0 0",
                  sPixReady, sStripValid, sStripData, sStripCol, sStripLast, sFrameDone);
      end
      rst = 1'b0;
      tick();
      total++;
      if (sPixReady !== 1'b1 || sStripValid !== 1'b0 || sFrameDone !== 1'b0) begin
         bad++;
         $display("[TB] FAIL after reset: got rdy=%b v=%b done=%b expected 1 0 0", sPixReady, sStripValid, sFrameDone);
      end
      for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) sImg[r][c] = 1'b1;
      applyStimulus(1'b1);
      total++;
      if (sStripValid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL drain entry: got v=%b expected 1", sStripValid);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (sStripValid !== 1'b0 || sPixReady !== 1'b1 || sStripData !== 4'h0) begin
         bad++;
         $display("[TB] FAIL async reset: got v=%b rdy=%b d=%h expected 0 1 0", sStripValid, sPixReady, sStripData);
      end
      #1 rst = 1'b0;
      tick();
   endtask

   task automatic test_identity();
      for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) sImg[r][c] = (r == c);
      applyStimulus(1'b0);
      checkOutput(0, 1'b0);
   endtask

   task automatic test_back_pressure();
      for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) sImg[r][c] = 1'b1;
      applyStimulus(1'b1);
      checkOutput(5, 1'b1);
   endtask

   task automatic test_resync();
      for (int i = 0; i < 6; i++) begin
         sPixValid = 1'b1;
         sPixData  = ((i / SW + i % SW) % 2 != 0);
         sPixSof   = (i == 0);
         tick();
      end
      for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) sImg[r][c] = ((r + c) % 2 == 0);
      applyStimulus(1'b1);
      checkOutput(0, 1'b0);
   endtask

   task automatic test_reset_mid_drain();
      for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) sImg[r][c] = (r == c);
      applyStimulus(1'b1);
      sStripReady = 1'b1;
      tick();
      tick();
      sStripReady = 1'b0;
      total++;
      if (sStripCol !== 2'd2) begin
         bad++;
         $display("[TB] FAIL pre-reset col: got %0d expected 2", sStripCol);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (sStripValid !== 1'b0 || sStripCol !== 2'd0) begin
         bad++;
         $display("[TB] FAIL reset mid-drain: got v=%b col=%0d expected 0 0", sStripValid, sStripCol);
      end
      #1 rst = 1'b0;
      tick();
      for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) sImg[r][c] = ((r + c) % 2 == 0);
      applyStimulus(1'b0);
      checkOutput(0, 1'b0);
   endtask

   task automatic test_default_size();
      int  got = 0;
      int  cycles = 0;
      bit  rdy;
      for (int r = 0; r < BH; r++) for (int c = 0; c < BW; c++) bImg[r][c] = 1'($urandom_range(0, 1));
      for (int r = 0; r < BH; r++) begin
         for (int c = 0; c < BW; c++) begin
            bPixValid = 1'b1;
            bPixData  = bImg[r][c];
            bPixSof   = (r == 0) && (c == 0);
            tick();
         end
      end
      bPixValid = 1'b0;
      bPixSof   = 1'b0;
      while (got < BW && cycles < 400) begin
         cycles++;
         total++;
         if (bStripValid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL big valid cycle%0d: got %b expected 1", cycles, bStripValid);
         end
         rdy = 1'($urandom_range(0, 1));
         if (rdy) begin
            total++;
            if (bStripCol !== 5'(got) || bStripLast !== (got == BW - 1)) begin
               bad++;
               $display("[TB] FAIL big col: got col=%0d last=%b expected col=%0d last=%b",
                        bStripCol, bStripLast, got, (got == BW - 1));
            end
            total++;
            if (bStripData !== bigStrip(got)) begin
               bad++;
               $display("[TB] FAIL big data col%0d: got %h expected %h", got, bStripData, bigStrip(got));
            end
            total++;
            if (stripTransitions(bStripData) != modelTransitions(got)) begin
               bad++;
               $display("[TB] FAIL big transitions col%0d: got %0d expected %0d",
                        got, stripTransitions(bStripData), modelTransitions(got));
            end
         end
         bStripReady = rdy;
         tick();
         bStripReady = 1'b0;
         if (rdy) got++;
      end
      total++;
      if (got != BW) begin
         bad++;
         $display("[TB] FAIL big drain timeout: got %0d strips expected %0d", got, BW);
      end
      total++;
      if (bFrameDone !== 1'b1 || bPixReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL big frame end: got done=%b ready=%b expected 1 1", bFrameDone, bPixReady);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_back_pressure();
      test_resync();
      test_reset_mid_drain();
      test_default_size();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
